alu_operand_stage: RTL

Decode-to-execute pipeline stage that feeds `alu_new`. It registers decoded operands, immediates and ALU control, and forwards writeback results into operands both at capture and while an entry is held. It also provides a two-entry skid buffer so that `ready_o` to decode is a registered signal. Its outputs connect directly to `alu_new`'s `alu_operand_1_i`, `alu_operand_2_i`, `alu_control` and `func7_5`.

---
 rtl/alu_operand_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage feeding alu_new: two-entry (OUT + SKID) buffer with
// a registered ready, writeback forwarding at capture, and snooping of held entries.
module alu_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] imm_i,
    input  logic          use_imm_i,
    input  logic [2:0]    alu_control_i,
    input  logic          func7_5_i,
    input  logic          reg_write_i,
    input  logic          wb_reg_write_i,
    input  logic [AW-1:0] wb_rd_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] alu_operand_1_o,
    output logic [DW-1:0] alu_operand_2_o,
    output logic [2:0]    alu_control_o,
    output logic          func7_5_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          reg_write_o
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          use_imm;
        logic [2:0]    ctrl;
        logic          f7;
        logic          reg_write;
    } entry_t;

    localparam int OUT  = 0;
    localparam int SKID = 1;

    entry_t ent_q [2];
    entry_t ent_d [2];
    entry_t snoop [2];
    entry_t cap;
    logic   ready_q;
    logic   ready_d;
    logic   accept;
    logic   consume;
    logic   hit_rs1;
    logic   hit_rs2;

    // Held entries pick up a matching writeback every cycle; x0 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_snoop
            always_comb begin
                snoop[gi] = ent_q[gi];
                if (ent_q[gi].valid && wb_reg_write_i && (wb_rd_addr_i != '0)) begin
                    if (wb_rd_addr_i == ent_q[gi].rs1)
                        snoop[gi].op1 = wb_data_i;
                    if (!ent_q[gi].use_imm && (wb_rd_addr_i == ent_q[gi].rs2))
                        snoop[gi].op2 = wb_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        hit_rs1 = wb_reg_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs1_addr_i);
        hit_rs2 = wb_reg_write_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs2_addr_i);

        cap           = '0;
        cap.valid     = 1'b1;
        cap.rs1       = rs1_addr_i;
        cap.rs2       = rs2_addr_i;
        cap.rd        = rd_addr_i;
        cap.use_imm   = use_imm_i;
        cap.ctrl      = alu_control_i;
        cap.reg_write = reg_write_i;
        // Only shifts use bit 30 with an immediate; otherwise ADDI would look like SUB.
        cap.f7        = (use_imm_i && (alu_control_i != 3'd5)) ? 1'b0 : func7_5_i;

        if (rs1_addr_i == '0)
            cap.op1 = '0;
        else if (hit_rs1)
            cap.op1 = wb_data_i;
        else
            cap.op1 = rs1_data_i;

        if (use_imm_i)
            cap.op2 = imm_i;
        else if (rs2_addr_i == '0)
            cap.op2 = '0;
        else if (hit_rs2)
            cap.op2 = wb_data_i;
        else
            cap.op2 = rs2_data_i;
    end

    always_comb begin
        accept      = valid_i && ready_q;
        consume     = ent_q[OUT].valid && ready_i;
        ent_d[OUT]  = snoop[OUT];
        ent_d[SKID] = snoop[SKID];

        if (flush_i) begin
            ent_d[OUT].valid  = 1'b0;
            ent_d[SKID].valid = 1'b0;
        end else begin
            if (consume) begin
                if (ent_q[SKID].valid) begin
                    ent_d[OUT]        = snoop[SKID];
                    ent_d[SKID].valid = 1'b0;
                end else begin
                    ent_d[OUT].valid = 1'b0;
                end
            end
            // ready_q high implies SKID is empty, so an accept never collides with SKID->OUT.
            if (accept) begin
                if (!ent_q[OUT].valid || consume)
                    ent_d[OUT] = cap;
                else
                    ent_d[SKID] = cap;
            end
        end

        ready_d = !ent_d[SKID].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q[OUT]  <= '0;
            ent_q[SKID] <= '0;
            ready_q     <= 1'b1;
        end else begin
            ent_q[OUT]  <= ent_d[OUT];
            ent_q[SKID] <= ent_d[SKID];
            ready_q     <= ready_d;
        end
    end

    assign ready_o         = ready_q;
    assign valid_o         = ent_q[OUT].valid;
    assign alu_operand_1_o = ent_q[OUT].op1;
    assign alu_operand_2_o = ent_q[OUT].op2;
    assign alu_control_o   = ent_q[OUT].ctrl;
    assign func7_5_o       = ent_q[OUT].f7;
    assign rd_addr_o       = ent_q[OUT].rd;
    assign reg_write_o     = ent_q[OUT].reg_write;

endmodule
